cnt_seq_ctrl: RTL and testbench

Sequencer for a 4-bit enable-driven counter (sync active-low clear, increments when its enable is high at a clock edge).
Generates the counter's clear and increment-enable, paced by a programmable prescaler.
Runs until a loaded target count is reached, then signals completion.
Sits between the lab's push-button/control logic and the counter datapath; keeps an internal mirror of the count for status.

---
 rtl/cnt_seq_ctrl.sv | 63 ++++++
 tb/tb_cnt_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: prescaled run/pause/done sequencer driving a 4-bit counter's clear and increment-enable
module cnt_seq_ctrl #(
  parameter int PRESCALE = 4,
  parameter int PS_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] target,
  output logic       inc_out,
  output logic       cnt_rst_n,
  output logic [3:0] count_mirror,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  logic [PS_W-1:0] ps;
  logic [3:0] tgt_q;
  logic go, act, tick, last;
  assign busy = (state == RUN) || (state == PAUSE);
  assign go   = !clear && start && ((state == IDLE) || (state == DONE));
  assign act  = !clear && busy && !pause;
  assign tick = act && (ps == PS_MAX);
  assign last = tick && ((count_mirror + 4'd1) == tgt_q);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      ps           <= '0;
      tgt_q        <= '0;
      count_mirror <= '0;
      inc_out      <= 1'b0;
      done         <= 1'b0;
      cnt_rst_n    <= 1'b0;
    end else begin
      cnt_rst_n <= !(clear || go);
      inc_out   <= tick;
      done      <= go ? (target == 4'd0) : last;
      if (clear) begin
        state        <= IDLE;
        ps           <= '0;
        count_mirror <= '0;
      end else if (go) begin
        tgt_q        <= target;
        count_mirror <= '0;
        ps           <= '0;
        state        <= (target == 4'd0) ? DONE : RUN;
      end else if (busy) begin
        state <= pause ? PAUSE : (last ? DONE : RUN);
        if (act) begin
          ps <= tick ? '0 : ps + PS_W'(1);
          if (tick) count_mirror <= count_mirror + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed checks of cnt_seq_ctrl at PRESCALE=4 and PRESCALE=1 with attached counter models
module tb_cnt_seq_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic s4 = 1'b0, p4 = 1'b0, c4 = 1'b0;
  logic [3:0] t4 = '0;
  logic i4, r4, b4, dn4;
  logic [3:0] m4;
  logic [1:0] st4;
  logic s1 = 1'b0, p1 = 1'b0, c1 = 1'b0;
  logic [3:0] t1 = '0;
  logic i1, r1, b1, dn1;
  logic [3:0] m1;
  logic [1:0] st1;
  logic [4:0] cnt4, cnt1;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] inc_v, done_v;
  always #5 CLK = ~CLK;
  cnt_seq_ctrl #(.PRESCALE(4), .PS_W(8)) d4 (
    .CLK(CLK), .RST(RST), .start(s4), .pause(p4), .clear(c4), .target(t4),
    .inc_out(i4), .cnt_rst_n(r4), .count_mirror(m4), .busy(b4), .done(dn4), .state(st4)
  );
  cnt_seq_ctrl #(.PRESCALE(1), .PS_W(8)) d1 (
    .CLK(CLK), .RST(RST), .start(s1), .pause(p1), .clear(c1), .target(t1),
    .inc_out(i1), .cnt_rst_n(r1), .count_mirror(m1), .busy(b1), .done(dn1), .state(st1)
  );
  always_ff @(posedge CLK) begin
    cnt4 <= !r4 ? 5'd0 : cnt4 + {4'd0, i4};
    cnt1 <= !r1 ? 5'd0 : cnt1 + {4'd0, i1};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    step();
    chk("rst_state", {30'd0, st4}, 0);
    chk("rst_outs", {28'd0, i4, r4, b4, dn4}, 0);
    chk("rst_mirror", {28'd0, m4}, 0);
    RST = 1'b0;
    step();
    chk("rel_cnt_rst_n", {31'd0, r4}, 1);
    chk("rel_idle", {30'd0, st4}, 0);
    s4 = 1'b1; t4 = 4'd3;
    step();
    s4 = 1'b0;
    chk("t1_start_state", {30'd0, st4}, 1);
    chk("t1_clr_low", {31'd0, r4}, 0);
    chk("t1_busy", {31'd0, b4}, 1);
    inc_v = '0; done_v = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) chk("t1_clr_high", {31'd0, r4}, 1);
      inc_v[k] = i4; done_v[k] = dn4;
    end
    chk("t1_inc_pattern", inc_v, 32'h1110);
    chk("t1_done_pattern", done_v, 32'h1000);
    chk("t1_end_state", {30'd0, st4}, 3);
    chk("t1_end_mirror", {28'd0, m4}, 3);
    chk("t1_end_busy", {31'd0, b4}, 0);
    step();
    chk("t1_counter", {27'd0, cnt4}, 3);
    chk("t1_done_pulse", {31'd0, dn4}, 0);
    s4 = 1'b1; t4 = 4'd3;
    step();
    s4 = 1'b0;
    inc_v = '0; done_v = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 5) p4 = 1'b1;
      if (k == 11) p4 = 1'b0;
      if (k == 6) chk("t2_pause_state", {30'd0, st4}, 2);
      if (k == 8) chk("t2_pause_mirror", {28'd0, m4}, 1);
      inc_v[k] = i4; done_v[k] = dn4;
    end
    chk("t2_inc_pattern", inc_v, 32'h44010);
    chk("t2_done_pattern", done_v, 32'h40000);
    chk("t2_end_state", {30'd0, st4}, 3);
    chk("t2_counter", {27'd0, cnt4}, 3);
    s4 = 1'b1; t4 = 4'd5;
    step();
    s4 = 1'b0;
    repeat (8) step();
    chk("t3_mirror2", {28'd0, m4}, 2);
    c4 = 1'b1; s4 = 1'b1;
    step();
    c4 = 1'b0; s4 = 1'b0;
    chk("t3_clr_state", {30'd0, st4}, 0);
    chk("t3_clr_mirror", {28'd0, m4}, 0);
    chk("t3_clr_outs", {29'd0, r4, dn4, i4}, 0);
    step();
    chk("t3_clr_release", {31'd0, r4}, 1);
    repeat (6) step();
    chk("t3_stay_idle", {30'd0, st4}, 0);
    chk("t3_counter", {27'd0, cnt4}, 0);
    s4 = 1'b1; t4 = 4'd0;
    step();
    s4 = 1'b0;
    chk("t4_zero_state", {30'd0, st4}, 3);
    chk("t4_zero_done", {31'd0, dn4}, 1);
    chk("t4_zero_busy", {31'd0, b4}, 0);
    inc_v = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      inc_v[k] = i4;
      if (k == 1) chk("t4_zero_done_end", {31'd0, dn4}, 0);
    end
    chk("t4_zero_no_inc", inc_v, 0);
    s4 = 1'b1; t4 = 4'd2;
    step();
    s4 = 1'b0;
    done_v = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin s4 = 1'b1; t4 = 4'd9; end
      step();
      s4 = 1'b0;
      done_v[k] = dn4;
    end
    chk("t4_ignore_done", done_v, 32'h100);
    chk("t4_ignore_mirror", {28'd0, m4}, 2);
    s1 = 1'b1; t1 = 4'd0;
    step();
    chk("t5_pre_done", {30'd0, st1}, 3);
    t1 = 4'd15;
    step();
    s1 = 1'b0;
    chk("t5_start_state", {30'd0, st1}, 1);
    inc_v = '0; done_v = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("t5_mirror_%0d", k), {28'd0, m1}, k);
      inc_v[k] = i1; done_v[k] = dn1;
    end
    chk("t5_inc_pattern", inc_v, 32'hFFFE);
    chk("t5_done_pattern", done_v, 32'h8000);
    step();
    chk("t5_hold", {26'd0, st1, m1}, {26'd0, 2'd3, 4'd15});
    chk("t5_quiet", {30'd0, i1, dn1}, 0);
    chk("t5_counter", {27'd0, cnt1}, 15);
    s4 = 1'b1; t4 = 4'd5;
    step();
    s4 = 1'b0;
    repeat (4) step();
    chk("t6_pre_inc", {31'd0, i4}, 1);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_state", {30'd0, st4}, 0);
    chk("t6_async_outs", {27'd0, i4, r4, b4, dn4, 1'b0}, 0);
    chk("t6_async_mirror", {28'd0, m4}, 0);
    step();
    RST = 1'b0;
    repeat (3) step();
    chk("t6_after_state", {30'd0, st4}, 0);
    chk("t6_after_clr", {31'd0, r4}, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
